lc3_mem_sequencer: RTL and testbench

Sequences the memory-access phase of LC-3 load/store instructions, sitting directly upstream of the memory-access stage. It accepts a memory instruction from execute (opcode, effective address, store data) and drives `mem_state`, `M_Control`, `M_Addr`, `M_Data` cycle by cycle. It inserts the extra indirect-read cycle for LDI/STI. It captures the load result from `memout` for writeback and pulses `done` when the access completes.

---
 rtl/lc3_mem_sequencer_if.sv | 24 ++
 rtl/lc3_mem_sequencer.sv | 68 ++++++
 tb/tb_lc3_mem_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lc3_mem_sequencer_if.sv
// lc3_mem_sequencer_if: execute/memory-stage bus between the sequencer and its neighbours
interface lc3_mem_sequencer_if #(parameter int WIDTH = 16);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] addr_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] memout;
  logic [1:0]       mem_state;
  logic             M_Control;
  logic [WIDTH-1:0] M_Addr;
  logic [WIDTH-1:0] M_Data;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] mem_result;
  modport master (
    output start, opcode, addr_in, data_in, memout,
    input  mem_state, M_Control, M_Addr, M_Data, busy, done, err, mem_result
  );
  modport slave (
    input  start, opcode, addr_in, data_in, memout,
    output mem_state, M_Control, M_Addr, M_Data, busy, done, err, mem_result
  );
endinterface

// File: rtl/lc3_mem_sequencer.sv
// lc3_mem_sequencer: LC-3 load/store memory-phase FSM; MEMSEQ_PTR_LATCH_EN latches the indirect pointer into M_Addr
module lc3_mem_sequencer #(parameter int WIDTH = 16) (
  input logic i_clock,
  input logic i_reset,
  lc3_mem_sequencer_if.slave bus
);
  localparam logic [1:0] S_RD   = 2'd0;
  localparam logic [1:0] S_IND  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;
  logic [1:0]       r_state;
  logic             r_store;
  logic             r_ctl;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_result;
  logic             w_mem;
  logic             w_ind;
  logic             w_start;
  assign w_mem   = bus.opcode[1] && bus.opcode[3:2] != 2'b11;
  assign w_ind   = bus.opcode[3:2] == 2'b10;
  assign w_start = r_state == S_IDLE && bus.start;
  // State encoding equals the mem_state code, so the output is a plain register copy
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_ctl    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_result <= '0;
    end else begin
      r_done <= r_state == S_RD || r_state == S_WR;
      r_err  <= w_start && !w_mem;
      if (w_start && w_mem) begin
        r_state <= w_ind ? S_IND : (bus.opcode[0] ? S_WR : S_RD);
        r_store <= bus.opcode[0];
        r_addr  <= bus.addr_in;
        r_data  <= bus.data_in;
        r_ctl   <= 1'b0;
      end else if (r_state == S_IND) begin
        r_state <= r_store ? S_WR : S_RD;
`ifdef MEMSEQ_PTR_LATCH_EN
        r_addr  <= bus.memout;
        r_ctl   <= 1'b0;
`else
        r_ctl   <= 1'b1;
`endif
      end else if (r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_ctl   <= 1'b0;
        if (r_state == S_RD) r_result <= bus.memout;
      end
    end
  end
  assign bus.mem_state  = r_state;
  assign bus.M_Control  = r_ctl;
  assign bus.M_Addr     = r_addr;
  assign bus.M_Data     = r_data;
  assign bus.busy       = r_state != S_IDLE;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.mem_result = r_result;
endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// tb_lc3_mem_sequencer: directed and randomized checks against a schedule-based model
module tb_lc3_mem_sequencer;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  int checks = 0;
  int failures = 0;
  lc3_mem_sequencer_if #(.WIDTH(16)) bus ();
  lc3_mem_sequencer #(.WIDTH(16)) dut (.i_clock(clk), .i_reset(rst_in), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef MEMSEQ_PTR_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif
  int          m_cur;
  int          m_sched[$];
  bit          m_second;
  logic [15:0] m_addr, m_data, m_result;
  bit          m_done, m_err, m_ctl;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_cur = 3; m_sched.delete(); m_second = 0;
    m_addr = 0; m_data = 0; m_result = 0;
    m_done = 0; m_err = 0; m_ctl = 0;
  endtask
  task automatic model_step(input bit st, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] mo);
    int old;
    int fin;
    old = m_cur;
    m_done = old == 0 || old == 2;
    m_err = 0;
    if (old == 0) m_result = mo;
    if (old == 1 && LATCH) m_addr = mo;
    if (m_sched.size() > 0) begin
      m_cur = m_sched.pop_front();
      m_second = 1;
    end else begin
      m_cur = 3;
      m_second = 0;
    end
    if (old == 3 && st) begin
      if (op inside {4'd2, 4'd6, 4'd10, 4'd3, 4'd7, 4'd11}) begin
        m_addr = a;
        m_data = d;
        fin = (op inside {4'd3, 4'd7, 4'd11}) ? 2 : 0;
        if (op inside {4'd10, 4'd11}) begin
          m_cur = 1;
          m_sched.push_back(fin);
        end else m_cur = fin;
        m_second = 0;
      end else m_err = 1;
    end
    m_ctl = m_second && !LATCH;
  endtask
  task automatic compare();
    chk("mem_state", {14'd0, bus.mem_state}, m_cur[15:0]);
    chk("M_Control", {15'd0, bus.M_Control}, {15'd0, m_ctl});
    chk("M_Addr", bus.M_Addr, m_addr);
    chk("M_Data", bus.M_Data, m_data);
    chk("busy", {15'd0, bus.busy}, {15'd0, m_cur != 3});
    chk("done", {15'd0, bus.done}, {15'd0, m_done});
    chk("err", {15'd0, bus.err}, {15'd0, m_err});
    chk("mem_result", bus.mem_result, m_result);
  endtask
  task automatic cycle(input bit st, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] mo);
    bus.start = st; bus.opcode = op; bus.addr_in = a; bus.data_in = d; bus.memout = mo;
    @(posedge clk);
    if (rst_in) model_reset();
    else model_step(st, op, a, d, mo);
    #1;
    compare();
  endtask
  task automatic rst_pulse();
    bus.start = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    model_reset();
    chk("async_rst_state", {14'd0, bus.mem_state}, 16'd3);
    chk("async_rst_result", bus.mem_result, 16'h0000);
    chk("async_rst_done", {15'd0, bus.done}, 16'd0);
    #1 rst_in = 1'b0;
  endtask
  initial begin
    model_reset();
    cycle(1, 4'd2, 16'h1111, 16'h2222, 16'h3333);
    cycle(1, 4'd2, 16'h1111, 16'h2222, 16'h3333);
    chk("rst_hold_state", {14'd0, bus.mem_state}, 16'd3);
    chk("rst_hold_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_hold_addr", bus.M_Addr, 16'h0000);
    rst_in = 1'b0;
    cycle(1, 4'd2, 16'h3000, 16'h0000, 16'h0000);
    chk("ld_state", {14'd0, bus.mem_state}, 16'd0);
    chk("ld_addr", bus.M_Addr, 16'h3000);
    chk("ld_ctl", {15'd0, bus.M_Control}, 16'd0);
    cycle(0, 4'd0, 16'h0, 16'h0, 16'hBEEF);
    chk("ld_done", {15'd0, bus.done}, 16'd1);
    chk("ld_result", bus.mem_result, 16'hBEEF);
    chk("ld_idle", {14'd0, bus.mem_state}, 16'd3);
    cycle(1, 4'd11, 16'h3010, 16'h1234, 16'h0000);
    chk("sti_ind", {14'd0, bus.mem_state}, 16'd1);
    chk("sti_ind_addr", bus.M_Addr, 16'h3010);
    cycle(0, 4'd0, 16'h0, 16'h0, 16'h4000);
    chk("sti_wr", {14'd0, bus.mem_state}, 16'd2);
    chk("sti_data", bus.M_Data, 16'h1234);
    chk("sti_addr", bus.M_Addr, LATCH ? 16'h4000 : 16'h3010);
    chk("sti_ctl", {15'd0, bus.M_Control}, LATCH ? 16'd0 : 16'd1);
    cycle(0, 4'd0, 16'h0, 16'h0, 16'h0);
    chk("sti_done", {15'd0, bus.done}, 16'd1);
    cycle(1, 4'd1, 16'hAAAA, 16'h5555, 16'h0);
    chk("add_err", {15'd0, bus.err}, 16'd1);
    chk("add_busy", {15'd0, bus.busy}, 16'd0);
    chk("add_addr_kept", bus.M_Addr, LATCH ? 16'h4000 : 16'h3010);
    cycle(0, 4'd0, 16'h0, 16'h0, 16'h0);
    chk("add_err_clear", {15'd0, bus.err}, 16'd0);
    chk("add_no_done", {15'd0, bus.done}, 16'd0);
    cycle(1, 4'd10, 16'h3020, 16'h0, 16'h0);
    cycle(1, 4'd3, 16'h6000, 16'h7777, 16'h5000);
    chk("ldi_ignore_start", {14'd0, bus.mem_state}, 16'd0);
    cycle(0, 4'd0, 16'h0, 16'h0, 16'h9999);
    chk("ldi_done", {15'd0, bus.done}, 16'd1);
    chk("ldi_result", bus.mem_result, 16'h9999);
    cycle(1, 4'd3, 16'h5000, 16'h4321, 16'h0);
    chk("b2b_wr", {14'd0, bus.mem_state}, 16'd2);
    cycle(0, 4'd0, 16'h0, 16'h0, 16'h0);
    chk("b2b_done", {15'd0, bus.done}, 16'd1);
    cycle(1, 4'd10, 16'h3030, 16'h0, 16'h0);
    rst_pulse();
    cycle(0, 4'd0, 16'h0, 16'h0, 16'h0);
    chk("rst_no_done", {15'd0, bus.done}, 16'd0);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
           4'({$urandom_range(0, 2), 1'b1, 1'($urandom)});
      if ($urandom_range(0, 99) == 0) rst_pulse();
      cycle(1'($urandom_range(0, 1)), op, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
